// File: rtl/itype_exec_pipe_if.sv
// Handshake bundle for the I-type execute pipe: an instruction stream in,
// a result/status/destination stream out.
interface itype_exec_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic [7:0]        status;
    logic [REG_AW-1:0] wb_addr;

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, result, status, wb_addr
    );

    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, result, status, wb_addr
    );
endinterface

// File: rtl/itype_exec_pipe.sv
// Two-stage MIPS I-type ALU pipe with a private register file. S1 holds the
// decoded instruction, execute is combinational out of S1, and S2 holds the
// result until the downstream consumer takes it. The register write happens
// on the output handshake, so S2 doubles as the bypass source.
module itype_exec_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int RESET_REGS = 1
) (
    input  logic               clk,
    input  logic               reset,
    itype_exec_pipe_if.slave   bus
);
    localparam int NREGS = 2 ** REG_AW;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [7:0]        status;
        logic [REG_AW-1:0] wb;
        logic              we;
    } s2_t;

    logic [DATA_W-1:0] regs [NREGS];

    logic              s1_valid;
    logic [5:0]        s1_op;
    logic [REG_AW-1:0] s1_rs, s1_rt;
    logic [DATA_W-1:0] s1_imm;

    logic s2_valid;
    s2_t  s2, ex;

    logic [5:0]        in_op;
    logic [15:0]       in_imm;
    logic signed [31:0] in_lui;
    logic [DATA_W-1:0] in_ext;

    logic              s1_adv, accept, out_fire, wr_en;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W:0]   sum;
    logic              legal, ovf, carry, supp;

    assign s1_adv      = s1_valid & (!s2_valid | (bus.out_valid & bus.out_ready));
    assign bus.in_ready = !s1_valid | s1_adv;
    assign accept      = bus.in_valid & bus.in_ready;
    assign out_fire    = s2_valid & bus.out_ready;
    assign wr_en       = out_fire & s2.we;

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2.result;
    assign bus.status    = s2.status;
    assign bus.wb_addr   = s2.wb;

    assign in_op  = bus.instr[31:26];
    assign in_imm = bus.instr[15:0];
    assign in_lui = {in_imm, 16'h0000};

    // Immediate extension is decided at capture so execute sees a ready operand.
    always_comb begin
        in_ext = DATA_W'(in_imm);
        case (in_op)
            6'h08, 6'h09, 6'h0A, 6'h0B: in_ext = DATA_W'($signed(in_imm));
            6'h0F:                      in_ext = DATA_W'(in_lui);
            default:                    in_ext = DATA_W'(in_imm);
        endcase
    end

    // Stage 1 capture; drains into S2 when S2 is free or being emptied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_rs    <= '0;
            s1_rt    <= '0;
            s1_imm   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_rs    <= bus.instr[21 +: REG_AW];
            s1_rt    <= bus.instr[16 +: REG_AW];
            s1_imm   <= in_ext;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Execute: operand fetch with S2 bypass, ALU, flags and write enable.
    always_comb begin
        op_a = (s1_rs == '0) ? '0 : regs[s1_rs];
        if (s2_valid && s2.we && s2.wb == s1_rs && s1_rs != '0)
            op_a = s2.result;
        sum   = {1'b0, op_a} + {1'b0, s1_imm};
        legal = (s1_op[5:3] == 3'b001);
        ovf   = 1'b0;
        carry = 1'b0;
        ex    = '0;
        case (s1_op)
            6'h08, 6'h09: begin
                ex.result = sum[DATA_W-1:0];
                carry     = sum[DATA_W];
                ovf       = (op_a[DATA_W-1] == s1_imm[DATA_W-1]) &&
                            (sum[DATA_W-1] != op_a[DATA_W-1]);
            end
            6'h0A:   ex.result = DATA_W'($signed(op_a) < $signed(s1_imm));
            6'h0B:   ex.result = DATA_W'(op_a < s1_imm);
            6'h0C:   ex.result = op_a & s1_imm;
            6'h0D:   ex.result = op_a | s1_imm;
            6'h0E:   ex.result = op_a ^ s1_imm;
            6'h0F:   ex.result = s1_imm;
            default: ex.result = '0;
        endcase
        // Only signed ADDI drops its write on overflow; ADDIU just reports it.
        supp      = !legal || (s1_op == 6'h08 && ovf);
        ex.we     = (s1_rt != '0) && !supp;
        ex.wb     = s1_rt;
        ex.status = {2'b00, supp, !legal, ovf, carry,
                     ex.result[DATA_W-1], (ex.result == '0)};
    end

    // Stage 2 holds while stalled, reloads or empties on the output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2       <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2       <= ex;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    generate
        if (RESET_REGS != 0) begin : g_rf_rst
            // Register file with reset clear; written as the result leaves S2.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < NREGS; i++) regs[i] <= '0;
                end else if (wr_en) begin
                    regs[s2.wb] <= s2.result;
                end
            end
        end else begin : g_rf
            // Register file without reset; written as the result leaves S2.
            always_ff @(posedge clk) begin
                if (wr_en) regs[s2.wb] <= s2.result;
            end
        end
    endgenerate
endmodule

// File: tb/tb_itype_exec_pipe.sv
// Scoreboard bench for itype_exec_pipe: each accepted instruction pushes its
// expected result/status/destination, the output monitor pops and compares.
module tb_itype_exec_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_out = 0;
    int   n_in = 0;

    typedef struct {
        logic [31:0] result;
        logic [7:0]  status;
        logic [4:0]  wb;
    } exp_t;
    exp_t exp_q[$];

    itype_exec_pipe_if #(.DATA_W(32), .REG_AW(5)) bus ();

    itype_exec_pipe #(.DATA_W(32), .REG_AW(5), .RESET_REGS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Output monitor: a handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            exp_t e;
            n_out++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got result=%h status=%h wb=%0d, need none",
                         bus.result, bus.status, bus.wb_addr);
            end else begin
                e = exp_q.pop_front();
                if (bus.result !== e.result || bus.status !== e.status || bus.wb_addr !== e.wb) begin
                    failures++;
                    $display("FAIL output: got result=%h status=%h wb=%0d, need result=%h status=%h wb=%0d",
                             bus.result, bus.status, bus.wb_addr, e.result, e.status, e.wb);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] r,
                         input logic [7:0] st, input logic [4:0] wb);
        int budget = 0;
        bit done = 0;
        exp_t e;
        e.result = r; e.status = st; e.wb = wb;
        bus.in_valid = 1'b1;
        bus.instr = ins;
        while (!done && budget < 100) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                n_in++;
                done = 1;
            end
            @(posedge clk); #1;
            budget++;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL issue_timeout: got in_ready=0 for 100 cycles, need 1");
        end
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending, need 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b need 0", bus.out_valid); end
        if (bus.result !== 32'h0)   begin failures++; $display("FAIL rst_result: got %h need 0", bus.result); end
        if (bus.status !== 8'h0)    begin failures++; $display("FAIL rst_status: got %h need 0", bus.status); end
        if (bus.wb_addr !== 5'h0)   begin failures++; $display("FAIL rst_wb_addr: got %h need 0", bus.wb_addr); end
        if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready: got %b need 1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_addi_chain();
        issue(enc(6'h08, 5'd0, 5'd1, 16'd5),    32'h5,        8'h00, 5'd1);
        issue(enc(6'h08, 5'd1, 5'd2, 16'hFFF9), 32'hFFFFFFFE, 8'h02, 5'd2);
        drain();
        issue(enc(6'h0D, 5'd2, 5'd8, 16'h0),    32'hFFFFFFFE, 8'h02, 5'd8);
        // carry out of the add with no signed overflow
        issue(enc(6'h09, 5'd2, 5'd10, 16'd5),   32'h3,        8'h04, 5'd10);
        drain();
    endtask

    task automatic test_overflow();
        issue(enc(6'h0F, 5'd0, 5'd3, 16'h7FFF), 32'h7FFF0000, 8'h00, 5'd3);
        issue(enc(6'h0D, 5'd3, 5'd3, 16'hFFFF), 32'h7FFFFFFF, 8'h00, 5'd3);
        issue(enc(6'h08, 5'd3, 5'd4, 16'd1),    32'h80000000, 8'h2A, 5'd4);
        drain();
        issue(enc(6'h0D, 5'd4, 5'd9, 16'h0),    32'h0,        8'h01, 5'd9);
        issue(enc(6'h09, 5'd3, 5'd4, 16'd1),    32'h80000000, 8'h0A, 5'd4);
        drain();
        issue(enc(6'h0D, 5'd4, 5'd9, 16'h0),    32'h80000000, 8'h02, 5'd9);
        // LUI with bit 15 set gives a negative operand
        issue(enc(6'h0F, 5'd0, 5'd14, 16'h8001), 32'h80010000, 8'h02, 5'd14);
        drain();
    endtask

    task automatic test_compare_logic();
        issue(enc(6'h0A, 5'd6, 5'd5, 16'hFFFF), 32'h0,  8'h01, 5'd5);
        issue(enc(6'h0B, 5'd6, 5'd5, 16'hFFFF), 32'h1,  8'h00, 5'd5);
        issue(enc(6'h0C, 5'd3, 5'd7, 16'h00F0), 32'hF0, 8'h00, 5'd7);
        issue(enc(6'h0E, 5'd7, 5'd7, 16'h00F0), 32'h0,  8'h01, 5'd7);
        drain();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        issue(enc(6'h08, 5'd0,  5'd11, 16'd1), 32'h1, 8'h00, 5'd11);
        issue(enc(6'h08, 5'd11, 5'd12, 16'd1), 32'h2, 8'h00, 5'd12);
        bus.in_valid = 1'b1;
        bus.instr = enc(6'h08, 5'd12, 5'd13, 16'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks += 3;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %b need 0", i, bus.in_ready); end
            if (bus.out_valid !== 1'b1 || bus.result !== 32'h1) begin
                failures++; $display("FAIL stall_hold_result[%0d]: got v=%b %h need v=1 00000001", i, bus.out_valid, bus.result);
            end
            if (bus.wb_addr !== 5'd11) begin failures++; $display("FAIL stall_hold_wb[%0d]: got %0d need 11", i, bus.wb_addr); end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        issue(enc(6'h08, 5'd12, 5'd13, 16'd1), 32'h3, 8'h00, 5'd13);
        drain();
        issue(enc(6'h0D, 5'd13, 5'd9, 16'h0), 32'h3, 8'h00, 5'd9);
        drain();
        checks++;
        if (n_out !== n_in) begin failures++; $display("FAIL stream_count: got %0d outputs need %0d", n_out, n_in); end
    endtask

    task automatic test_illegal();
        issue(enc(6'h23, 5'd1, 5'd5, 16'h0),  32'h0, 8'h31, 5'd5);
        drain();
        issue(enc(6'h0D, 5'd5, 5'd9, 16'h0),  32'h1, 8'h00, 5'd9);
        issue(enc(6'h08, 5'd0, 5'd0, 16'd9),  32'h9, 8'h00, 5'd0);
        issue(enc(6'h0D, 5'd0, 5'd9, 16'h0),  32'h0, 8'h01, 5'd9);
        drain();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        issue(enc(6'h08, 5'd0, 5'd1, 16'd100), 32'd100, 8'h00, 5'd1);
        issue(enc(6'h08, 5'd0, 5'd2, 16'd100), 32'd100, 8'h00, 5'd2);
        #2 reset = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b need 0", bus.out_valid); end
        if (bus.result !== 32'h0)   begin failures++; $display("FAIL midrst_result: got %h need 0", bus.result); end
        if (bus.wb_addr !== 5'h0)   begin failures++; $display("FAIL midrst_wb_addr: got %h need 0", bus.wb_addr); end
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        issue(enc(6'h08, 5'd0, 5'd1, 16'd3), 32'h3, 8'h00, 5'd1);
        drain();
        issue(enc(6'h0D, 5'd1, 5'd9, 16'h0), 32'h3, 8'h00, 5'd9);
        issue(enc(6'h0D, 5'd2, 5'd9, 16'h0), 32'h0, 8'h01, 5'd9);
        issue(enc(6'h0D, 5'd3, 5'd9, 16'h0), 32'h0, 8'h01, 5'd9);
        drain();
    endtask

    initial begin
        test_reset();
        test_addi_chain();
        test_overflow();
        test_compare_logic();
        test_stall();
        test_illegal();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
